// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;
  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] DIVZ_QUOT = '1;
  localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;
  typedef logic [4:0] iter_cnt_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step, borrow of a 33-bit subtract acts as sign
module div_step
  import div_pkg::*;
(
  input  logic [WIDTH-1:0] prem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] prem_o,
  output logic             qbit_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {prem_i, bit_i};
  assign diff    = shifted - {1'b0, dvs_i};
  assign qbit_o  = ~diff[WIDTH];
  // When the trial fails the shifted value is below the divisor, so its top bit is zero.
  assign prem_o  = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/divider_seq32.sv
// rtl/divider_seq32.sv - iterative 32-bit signed/unsigned divider with start/done handshake
module divider_seq32
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             zerof,
  output logic             negf,
  output logic             overf,
  output logic             carry
);
  state_e           state_q, state_d;
  iter_cnt_t        cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             zf_q, zf_d, nf_q, nf_d, of_q, of_d, cf_q, cf_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] fix_quot;

  // The dividend register doubles as the quotient: bits shift out the top, quotient bits in at the bottom.
  div_step u_step (
    .prem_i (prem_q),
    .bit_i  (dvd_q[WIDTH-1]),
    .dvs_i  (dvs_q),
    .prem_o (step_rem),
    .qbit_o (step_qbit)
  );

  assign fix_quot = magnitude(dvd_q, qneg_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (b == '0) ? DONE : RUN;
      RUN:     if (cnt_q == iter_cnt_t'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN) || (state_q == FIX);
    done = (state_q == DONE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    prem_d = prem_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    ovf_d  = ovf_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    zf_d   = zf_q;
    nf_d   = nf_q;
    of_d   = of_q;
    cf_d   = cf_q;
    case (state_q)
      IDLE: begin
        if (start && (b == '0)) begin
          quot_d = DIVZ_QUOT;
          rem_d  = a;
          zf_d   = 1'b0;
          nf_d   = DIVZ_QUOT[WIDTH-1];
          of_d   = 1'b0;
          cf_d   = 1'b1;
        end else if (start) begin
          dvd_d  = magnitude(a, signed_op & a[WIDTH-1]);
          dvs_d  = magnitude(b, signed_op & b[WIDTH-1]);
          prem_d = '0;
          cnt_d  = '0;
          qneg_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d = signed_op & a[WIDTH-1];
          ovf_d  = signed_op && (a == SIGNED_MIN) && (b == '1);
        end
      end
      RUN: begin
        dvd_d  = {dvd_q[WIDTH-2:0], step_qbit};
        prem_d = step_rem;
        cnt_d  = cnt_q + 1'b1;
      end
      FIX: begin
        quot_d = fix_quot;
        rem_d  = magnitude(prem_q, rneg_q);
        zf_d   = (fix_quot == '0);
        nf_d   = fix_quot[WIDTH-1];
        of_d   = ovf_q;
        cf_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      ovf_q  <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      zf_q   <= 1'b0;
      nf_q   <= 1'b0;
      of_q   <= 1'b0;
      cf_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      prem_q <= prem_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      ovf_q  <= ovf_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      zf_q   <= zf_d;
      nf_q   <= nf_d;
      of_q   <= of_d;
      cf_q   <= cf_d;
    end
  end

  assign quot  = quot_q;
  assign rem   = rem_q;
  assign zerof = zf_q;
  assign negf  = nf_q;
  assign overf = of_q;
  assign carry = cf_q;
endmodule

// File: tb/tb_divider_seq32.sv
// tb/tb_divider_seq32.sv - directed and random checks of divider_seq32 against an arithmetic model
module tb_divider_seq32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, zerof, negf, overf, carry;
  logic [31:0] quot, rem;

  int errors = 0;
  int checks = 0;

  divider_seq32 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .quot      (quot),
    .rem       (rem),
    .zerof     (zerof),
    .negf      (negf),
    .overf     (overf),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic sg, input logic [31:0] aa, input logic [31:0] bb,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic z, output logic n, output logic o, output logic c);
    longint sa, sb;
    o = 1'b0;
    c = 1'b0;
    if (bb == 0) begin
      q = 32'hFFFF_FFFF;
      r = aa;
      c = 1'b1;
    end else if (sg && aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
      o = 1'b1;
    end else if (sg) begin
      sa = longint'($signed(aa));
      sb = longint'($signed(bb));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = aa / bb;
      r = aa % bb;
    end
    z = (q == 0);
    n = q[31];
  endfunction

  task automatic check_outputs(input string tag, input logic [31:0] eq, input logic [31:0] er,
                               input logic ez, input logic en, input logic eo, input logic ec);
    check({tag, ".quot"}, quot, eq);
    check({tag, ".rem"}, rem, er);
    check({tag, ".flags"}, {zerof, negf, overf, carry}, {ez, en, eo, ec});
  endtask

  task automatic do_op(input string tag, input logic sg, input logic [31:0] aa, input logic [31:0] bb);
    logic [31:0] eq, er;
    logic ez, en, eo, ec;
    int cyc, bcnt;
    model(sg, aa, bb, eq, er, ez, en, eo, ec);
    @(negedge clk);
    start = 1'b1; signed_op = sg; a = aa; b = bb;
    @(negedge clk);
    start = 1'b0; signed_op = 1'($urandom); a = $urandom; b = $urandom;
    cyc = 1; bcnt = 0;
    while (!done && cyc < 60) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, cyc, (bb == 0) ? 1 : 34);
    check({tag, ".busy_cycles"}, bcnt, (bb == 0) ? 0 : 33);
    check({tag, ".busy_at_done"}, busy, 1'b0);
    check_outputs(tag, eq, er, ez, en, eo, ec);
    @(negedge clk);
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".hold_quot"}, quot, eq);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic rs;
    int pulses, first;
    logic [31:0] gq, gr;

    repeat (3) @(negedge clk);
    check("reset.busy_done", {busy, done}, 2'b00);
    check_outputs("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    do_op("u100_7", 1'b0, 32'd100, 32'd7);
    do_op("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7);
    do_op("s_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9);
    do_op("s_5_0", 1'b1, 32'd5, 32'd0);
    do_op("u_5_0", 1'b0, 32'd5, 32'd0);
    do_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("u_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

    // A second start during iteration 10 must be dropped, not queued.
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; first = 0; gq = '0; gr = '0;
    for (int i = 1; i <= 75; i++) begin
      if (done) begin
        pulses++;
        if (first == 0) begin first = i; gq = quot; gr = rem; end
      end
      if (i == 11) begin start = 1'b1; a = 32'd7; b = 32'd2; end
      else start = 1'b0;
      @(negedge clk);
    end
    check("ignore.latency", first, 34);
    check("ignore.pulses", pulses, 1);
    check("ignore.quot", gq, 32'd333);
    check("ignore.rem", gr, 32'd1);

    // Reset in the middle of a run aborts it with no done pulse.
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; a = 32'h0001_FFFF; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy_done", {busy, done}, 2'b00);
    check_outputs("abort", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) pulses++;
      @(negedge clk);
    end
    check("abort.no_activity", pulses, 0);
    do_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);

    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = -32'($urandom_range(1, 20));
        3:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if (rb == 32'd0 && i % 5 != 0) rb = 32'd9;
      do_op($sformatf("rand%0d", i), rs, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
